// File: rtl/mem_loader.sv
// Host-load front end for datamemory: frames the uart_rx byte stream as a 12-bit
// word count plus little-endian payload words and writes each word via the load port.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// HDR_LO | waiting for count[7:0]
// HDR_HI | waiting for count[11:8]
// DAT_LO | waiting for low byte of a payload word
// DAT_HI | waiting for high byte; its arrival issues the write
// DONE   | all words written, waiting for start
// ERR    | inter-byte timeout, waiting for start
module mem_loader #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              receive_en,
    output logic [ADDR_W-1:0] addr_input,
    output logic [DATA_W-1:0] data_input,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              fmt_err,
    output logic [11:0]       words_left
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DAT_LO = 3'd3,
        DAT_HI = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [7:0]        cnt_lo;
    logic [7:0]        word_lo;
    logic [ADDR_W-1:0] ptr;
    logic              armable;
    logic              load_start;
    logic              accept;
    logic              timeout_hit;

    assign busy        = (state == HDR_LO) || (state == HDR_HI) ||
                         (state == DAT_LO) || (state == DAT_HI);
    assign done        = (state == DONE);
    assign err         = (state == ERR);
    assign armable     = (state == IDLE) || (state == DONE) || (state == ERR);
    assign load_start  = armable && start;
    assign accept      = busy && rx_valid;
    assign timeout_hit = busy && !rx_valid && (timer == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = HDR_LO;
            HDR_LO: if (rx_valid) state_nxt = HDR_HI;
            HDR_HI: if (rx_valid)
                        state_nxt = ({rx_data[3:0], cnt_lo} == 12'd0) ? DONE : DAT_LO;
            DAT_LO: if (rx_valid) state_nxt = DAT_HI;
            DAT_HI: if (rx_valid)
                        state_nxt = (words_left == 12'd1) ? DONE : DAT_LO;
            default: state_nxt = IDLE;
        endcase
        if (timeout_hit) state_nxt = ERR;
    end

    // The write is registered so receive_en and the entry to DONE land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            receive_en <= 1'b0;
            addr_input <= '0;
            data_input <= '0;
            fmt_err    <= 1'b0;
            words_left <= '0;
            ptr        <= '0;
            timer      <= '0;
            cnt_lo     <= '0;
            word_lo    <= '0;
        end else begin
            receive_en <= 1'b0;
            if (load_start) begin
                ptr     <= BASE_ADDR;
                fmt_err <= 1'b0;
                timer   <= TMR_LOAD;
            end else if (busy) begin
                if (rx_valid)          timer <= TMR_LOAD;
                else if (timer != '0)  timer <= timer - TMR_W'(1);
            end
            if (accept) begin
                case (state)
                    HDR_LO: cnt_lo <= rx_data;
                    HDR_HI: begin
                        words_left <= {rx_data[3:0], cnt_lo};
                        if (rx_data[7:4] != 4'd0) fmt_err <= 1'b1;
                    end
                    DAT_LO: word_lo <= rx_data;
                    DAT_HI: begin
                        receive_en <= 1'b1;
                        addr_input <= ptr;
                        data_input <= DATA_W'({rx_data[3:0], word_lo});
                        ptr        <= ptr + ADDR_W'(1);
                        words_left <= words_left - 12'd1;
                        if (rx_data[7:4] != 4'd0) fmt_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: two instances (base 0 and base 4095) share one stimulus;
// frames are checked against a byte-level frame parser and hand-written vectors.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid;
    logic [7:0]  rx_data;
    logic        re_a, busy_a, done_a, err_a, fe_a;
    logic [11:0] addr_a, wl_a;
    logic [17:0] data_a;
    logic        re_b, busy_b, done_b, err_b, fe_b;
    logic [11:0] addr_b, wl_b;
    logic [17:0] data_b;

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(12), .DATA_W(18), .BASE_ADDR(12'd0), .TIMEOUT(50)) dut_a (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .receive_en(re_a), .addr_input(addr_a), .data_input(data_a), .busy(busy_a),
        .done(done_a), .err(err_a), .fmt_err(fe_a), .words_left(wl_a));

    mem_loader #(.ADDR_W(12), .DATA_W(18), .BASE_ADDR(12'hFFF), .TIMEOUT(50)) dut_b (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .receive_en(re_b), .addr_input(addr_b), .data_input(data_b), .busy(busy_b),
        .done(done_b), .err(err_b), .fmt_err(fe_b), .words_left(wl_b));

    int n_cmp = 0;
    int n_bad = 0;
    int b2b   = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    logic [11:0] cap_a_addr[$], cap_b_addr[$];
    logic [17:0] cap_a_data[$], cap_b_data[$];

    always @(negedge clk) begin
        if (re_a) begin cap_a_addr.push_back(addr_a); cap_a_data.push_back(data_a); end
        if (re_b) begin cap_b_addr.push_back(addr_b); cap_b_data.push_back(data_b); end
        if ((re_a && prev_a) || (re_b && prev_b)) b2b++;
        prev_a = re_a;
        prev_b = re_b;
    end

    typedef struct packed {
        logic [7:0]  first;
        logic [7:0]  nb;
        logic [3:0]  exp_n;
        logic [11:0] w0, w1, w2;
        logic        exp_fmt;
    } vec_t;

    vec_t        vecs [4];
    logic [7:0]  pool [20];
    logic [7:0]  frm[$];
    logic [11:0] exp_w[$];
    logic        exp_fmt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frm[i]) send_byte(frm[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
    endtask

    // Reference: parse the frame bytes directly into the words it should load.
    task automatic model_frame();
        int n;
        exp_w.delete();
        n = {frm[1][3:0], frm[0]};
        exp_fmt = (frm[1][7:4] != 4'd0);
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({frm[3+2*i][3:0], frm[2+2*i]});
            if (frm[3+2*i][7:4] != 4'd0) exp_fmt = 1'b1;
        end
    endtask

    task automatic clear_caps();
        cap_a_addr.delete(); cap_a_data.delete();
        cap_b_addr.delete(); cap_b_data.delete();
    endtask

    task automatic check_frame(input string tag);
        logic [11:0] ea;
        tick();
        tick();
        chk({tag, ".nwr_a"}, cap_a_addr.size(), exp_w.size());
        chk({tag, ".nwr_b"}, cap_b_addr.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < cap_a_addr.size() && i < cap_b_addr.size(); i++) begin
            chk($sformatf("%s.addr_a[%0d]", tag, i), cap_a_addr[i], 12'(i));
            chk($sformatf("%s.data_a[%0d]", tag, i), cap_a_data[i], {6'd0, exp_w[i]});
            ea = 12'hFFF + 12'(i);
            chk($sformatf("%s.addr_b[%0d]", tag, i), cap_b_addr[i], ea);
            chk($sformatf("%s.data_b[%0d]", tag, i), cap_b_data[i], {6'd0, exp_w[i]});
        end
        chk({tag, ".done"},  {done_a, done_b}, 2'b11);
        chk({tag, ".busy"},  {busy_a, busy_b, err_a, err_b}, 4'b0000);
        chk({tag, ".wleft"}, {wl_a, wl_b}, 24'd0);
        chk({tag, ".fmt"},   {fe_a, fe_b}, {exp_fmt, exp_fmt});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_state", {re_a, addr_a, data_a, busy_a, done_a, err_a, fe_a, wl_a}, 48'd0);

        // Reset while waiting for W_HI, with the W_HI byte arriving in the reset cycle.
        pulse_start();
        frm = '{8'h01, 8'h00, 8'h55};
        send_frame(0);
        chk("pre_rst_state", {busy_a, wl_a}, {1'b1, 12'd1});
        clear_caps();
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
        tick();
        rst = 1'b0; rx_valid = 1'b0;
        chk("rst_mid_outputs", {re_a, addr_a, data_a, busy_a, done_a, err_a, fe_a, wl_a}, 48'd0);
        repeat (4) tick();
        chk("rst_mid_nowrite", cap_a_addr.size() + cap_b_addr.size(), 0);

        pool = '{8'h02, 8'h00, 8'h34, 8'h01, 8'h78, 8'h0A,
                 8'h00, 8'h00,
                 8'h01, 8'h00, 8'hAB, 8'hF3,
                 8'h03, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h5A, 8'h10};
        vecs[0] = '{first: 8'd0,  nb: 8'd6, exp_n: 4'd2, w0: 12'h134, w1: 12'hA78, w2: 12'h000, exp_fmt: 1'b0};
        vecs[1] = '{first: 8'd6,  nb: 8'd2, exp_n: 4'd0, w0: 12'h000, w1: 12'h000, w2: 12'h000, exp_fmt: 1'b0};
        vecs[2] = '{first: 8'd8,  nb: 8'd4, exp_n: 4'd1, w0: 12'h3AB, w1: 12'h000, w2: 12'h000, exp_fmt: 1'b1};
        vecs[3] = '{first: 8'd12, nb: 8'd8, exp_n: 4'd3, w0: 12'hFFF, w1: 12'h000, w2: 12'h05A, exp_fmt: 1'b1};

        foreach (vecs[v]) begin
            frm.delete();
            for (int j = 0; j < int'(vecs[v].nb); j++) frm.push_back(pool[int'(vecs[v].first) + j]);
            exp_w.delete();
            if (vecs[v].exp_n > 0) exp_w.push_back(vecs[v].w0);
            if (vecs[v].exp_n > 1) exp_w.push_back(vecs[v].w1);
            if (vecs[v].exp_n > 2) exp_w.push_back(vecs[v].w2);
            exp_fmt = vecs[v].exp_fmt;
            clear_caps();
            pulse_start();
            send_frame(0);
            check_frame($sformatf("vec%0d", v));
        end
        chk("fmt_sticky_in_done", fe_a, 1'b1);
        pulse_start();
        chk("fmt_clear_on_start", {fe_a, busy_a}, 2'b01);
        rst = 1'b1; tick(); rst = 1'b0;

        // start while mid-frame is ignored; write latency and done timing.
        clear_caps();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        chk("wl_after_hdr", wl_a, 12'd2);
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h01, 0);
        chk("first_write_lat", {re_a, done_a, wl_a}, {1'b1, 1'b0, 12'd1});
        send_byte(8'h22, 0);
        send_byte(8'h02, 0);
        chk("last_write_done", {re_a, done_a, re_b, done_b}, 4'b1111);
        exp_w = '{12'h111, 12'h222};
        exp_fmt = 1'b0;
        check_frame("start_ignored");

        // start and rx_valid together: the byte is dropped.
        clear_caps();
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
        tick();
        start = 1'b0; rx_valid = 1'b0;
        frm = '{8'h01, 8'h00, 8'h11, 8'h02};
        send_frame(0);
        exp_w = '{12'h211};
        check_frame("start_drops_byte");

        // Timeout after 50 idle cycles mid-frame.
        clear_caps();
        pulse_start();
        frm = '{8'h01, 8'h00, 8'h12};
        send_frame(0);
        repeat (49) tick();
        chk("tmo_not_yet", {err_a, busy_a}, 2'b01);
        tick();
        chk("tmo_err", {err_a, busy_a, err_b, busy_b}, 4'b1010);
        repeat (3) tick();
        chk("tmo_nowrite", cap_a_addr.size(), 0);
        pulse_start();
        chk("tmo_restart", {busy_a, err_a}, 2'b10);
        frm = '{8'h00, 8'h00};
        send_frame(0);
        model_frame();
        check_frame("after_tmo");

        // Randomized frames with inter-byte gaps and ignored bytes in DONE.
        for (int r = 0; r < 30; r++) begin
            int cnt;
            logic [31:0] rv;
            cnt = $urandom_range(0, 4);
            frm.delete();
            frm.push_back(8'(cnt));
            frm.push_back(8'h00);
            for (int i = 0; i < cnt; i++) begin
                rv = $urandom;
                frm.push_back(rv[7:0]);
                frm.push_back(($urandom_range(0, 3) == 0) ? rv[15:8] : {4'h0, rv[11:8]});
            end
            model_frame();
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 0);
            clear_caps();
            pulse_start();
            send_frame(10);
            check_frame($sformatf("rnd%0d", r));
        end

        chk("no_back_to_back_we", b2b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
